// File: rtl/vga_scanout_if.sv
// Pixel stream from the frame-buffer reader into the VGA scan-out engine.
interface vga_scanout_if #(
    parameter int unsigned COLOR_BITS = 5
) ();
    logic                      in_valid;
    logic [3*COLOR_BITS-1:0]   in_data;
    logic                      in_sop;
    logic                      in_ready;

    modport master (output in_valid, in_data, in_sop, input in_ready);
    modport slave  (input in_valid, in_data, in_sop, output in_ready);
endinterface

// File: rtl/vga_scanout.sv
// VGA scan-out: programmable H/V timing, pixel FIFO, frame alignment and underflow recovery.
// Optional colour-bar generator enabled by defining VGA_SCANOUT_TESTBAR_EN.
module vga_scanout #(
    parameter int unsigned H_ACTIVE         = 640,
    parameter int unsigned H_FRONT          = 16,
    parameter int unsigned H_SYNC           = 96,
    parameter int unsigned H_BACK           = 48,
    parameter int unsigned V_ACTIVE         = 480,
    parameter int unsigned V_FRONT          = 10,
    parameter int unsigned V_SYNC           = 2,
    parameter int unsigned V_BACK           = 33,
    parameter int unsigned COLOR_BITS       = 5,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vga_scanout_if.slave          pix,
    output logic [COLOR_BITS-1:0] vga_rout,
    output logic [COLOR_BITS-1:0] vga_gout,
    output logic [COLOR_BITS-1:0] vga_bout,
    output logic                  vga_hsync_n,
    output logic                  vga_vsync_n,
    output logic                  vga_enable,
    output logic                  frame_start,
    output logic                  underflow,
`ifdef VGA_SCANOUT_TESTBAR_EN
    input  logic                  test_en,
`endif
    input  logic                  err_clear
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DW       = 3 * COLOR_BITS;
    localparam int unsigned EW       = DW + 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam logic        SYNC_IDLE = (SYNC_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {SEEK, ARMED, RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic [DW-1:0]   rgb_q, rgb_d;
    logic            en_q, en_d;
    logic            hsync_q, hsync_d, vsync_q, vsync_d;
    logic            fs_q, fs_d;
    logic            uf_q, uf_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            h_last_c, v_last_c, frame_end_c, origin_c;
    logic            act_c, hs_c, vs_c;
    logic            empty_c, push_c, pop_c;
    logic            head_sop_c;
    logic [DW-1:0]   head_data_c, pix_c;
    logic            disp_c, fs_c, set_uf_c;

    // Raster position decode
    always_comb begin
        h_last_c    = (hcnt_q == HW'(H_TOTAL - 1));
        v_last_c    = (vcnt_q == VW'(V_TOTAL - 1));
        frame_end_c = h_last_c && v_last_c;
        origin_c    = (hcnt_q == '0) && (vcnt_q == '0);
        act_c       = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
        hs_c        = (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
        vs_c        = (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);
        hcnt_d      = h_last_c ? '0 : hcnt_q + HW'(1);
        vcnt_d      = vcnt_q;
        if (h_last_c) begin
            vcnt_d = v_last_c ? '0 : vcnt_q + VW'(1);
        end
    end

`ifdef VGA_SCANOUT_TESTBAR_EN
    logic        test_q, test_d;
    logic [31:0] bar_idx_c;
    logic [DW-1:0] bar_pix_c;
    assign test_d    = frame_end_c ? test_en : test_q;
    assign bar_idx_c = (32'(hcnt_q) * 32'd8) / H_ACTIVE;
    assign bar_pix_c = {{COLOR_BITS{bar_idx_c[2]}}, {COLOR_BITS{bar_idx_c[1]}},
                        {COLOR_BITS{bar_idx_c[0]}}};
`endif

    assign empty_c     = (count_q == '0);
    assign push_c      = pix.in_valid && in_ready_q;
    assign head_sop_c  = mem_q[rd_ptr_q][EW-1];
    assign head_data_c = mem_q[rd_ptr_q][DW-1:0];

    // Alignment state machine: decides pop, pixel colour and error per clock
    always_comb begin
        state_d  = state_q;
        pop_c    = 1'b0;
        set_uf_c = 1'b0;
        fs_c     = 1'b0;
        disp_c   = 1'b0;
        pix_c    = '0;
        case (state_q)
            SEEK: begin
                if (!empty_c) begin
                    if (head_sop_c) state_d = ARMED;
                    else            pop_c   = 1'b1;
                end
            end
            ARMED: begin
                if (origin_c && !empty_c) begin
                    pop_c   = 1'b1;
                    pix_c   = head_data_c;
                    fs_c    = 1'b1;
                    disp_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (act_c) begin
                    disp_c = 1'b1;
                    if (empty_c) begin
                        set_uf_c = 1'b1;
                        state_d  = DRAIN;
                    end else if (head_sop_c && !origin_c) begin
                        set_uf_c = 1'b1;
                        state_d  = SEEK;
                    end else begin
                        pop_c = 1'b1;
                        pix_c = head_data_c;
                        fs_c  = origin_c;
                    end
                end
            end
            DRAIN: begin
                disp_c = act_c;
                if (frame_end_c) state_d = SEEK;
            end
            default: state_d = SEEK;
        endcase
`ifdef VGA_SCANOUT_TESTBAR_EN
        if (test_q) begin
            state_d  = state_q;
            pop_c    = 1'b0;
            set_uf_c = 1'b0;
            disp_c   = act_c;
            fs_c     = origin_c;
            pix_c    = bar_pix_c;
        end
`endif
    end

    // FIFO bookkeeping and registered output stage
    always_comb begin
        wr_ptr_d   = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        in_ready_d = (count_d < CW'(FIFO_DEPTH));
        en_d       = act_c && disp_c;
        rgb_d      = en_d ? pix_c : '0;
        hsync_d    = hs_c ^ SYNC_IDLE;
        vsync_d    = vs_c ^ SYNC_IDLE;
        fs_d       = fs_c;
        uf_d       = set_uf_c | (uf_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEEK;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            rgb_q      <= '0;
            en_q       <= 1'b0;
            hsync_q    <= SYNC_IDLE;
            vsync_q    <= SYNC_IDLE;
            fs_q       <= 1'b0;
            uf_q       <= 1'b0;
`ifdef VGA_SCANOUT_TESTBAR_EN
            test_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            rgb_q      <= rgb_d;
            en_q       <= en_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fs_q       <= fs_d;
            uf_q       <= uf_d;
`ifdef VGA_SCANOUT_TESTBAR_EN
            test_q     <= test_d;
`endif
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= {pix.in_sop, pix.in_data};
    end

    assign pix.in_ready = in_ready_q;
    assign vga_rout     = rgb_q[DW-1 -: COLOR_BITS];
    assign vga_gout     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign vga_bout     = rgb_q[COLOR_BITS-1:0];
    assign vga_hsync_n  = hsync_q;
    assign vga_vsync_n  = vsync_q;
    assign vga_enable   = en_q;
    assign frame_start  = fs_q;
    assign underflow    = uf_q;
endmodule
